// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b pipeline control types
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } lc3b_fwd_sel;

  typedef struct packed {
    logic    valid;
    lc3b_reg dest;
    logic    wr;
    logic    load;
    logic    mem;
    logic    branch;
  } lc3b_stage_info_t;

  localparam lc3b_stage_info_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/lc3b_raw_cmp.sv
// rtl/lc3b_raw_cmp.sv - read-after-write match of one ID source against one in-flight stage
module lc3b_raw_cmp
  import lc3b_types::*;
(
  input  logic    valid,
  input  lc3b_reg src,
  input  logic    use_src,
  input  lc3b_reg dest,
  input  logic    wr,
  output logic    match
);

  assign match = valid & use_src & wr & (src == dest);

endmodule

// File: rtl/lc3b_pipe_ctrl.sv
// rtl/lc3b_pipe_ctrl.sv - hazard, stall, flush and forwarding control for the LC-3b pipeline
module lc3b_pipe_ctrl
  import lc3b_types::*;
#(
  parameter int MEM_STAGES = 1,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 16,
  localparam int STAGES    = 4 + MEM_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_resp,
  input  logic              d_mem_resp,
  input  logic              id_valid,
  input  lc3b_reg           id_src1,
  input  lc3b_reg           id_src2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  lc3b_reg           id_dest,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              id_mem,
  input  logic              id_branch,
  input  logic              wb_taken,
  output logic [STAGES-1:0] stage_load,
  output logic [STAGES-1:0] stage_valid,
  output logic              d_mem_req,
  output logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int EX = 2;
  localparam int LM = STAGES - 2;
  localparam int WB = STAGES - 1;

  logic             v_if, v_id;
  lc3b_stage_info_t info [EX:WB];
  logic [EX:WB]     m_a, m_b;
  logic             mem_stall, raw_stall, fetch_stall, any_stall;
  lc3b_fwd_sel      sel_a, sel_b;

  for (genvar s = EX; s <= WB; s++) begin : g_cmp
    lc3b_raw_cmp u_cmp_a (
      .valid(id_valid & info[s].valid), .src(id_src1), .use_src(id_use1),
      .dest(info[s].dest), .wr(info[s].wr), .match(m_a[s])
    );
    lc3b_raw_cmp u_cmp_b (
      .valid(id_valid & info[s].valid), .src(id_src2), .use_src(id_use2),
      .dest(info[s].dest), .wr(info[s].wr), .match(m_b[s])
    );
  end

  always_comb begin
    flush       = info[WB].valid & info[WB].branch & wb_taken;
    mem_stall   = info[LM].valid & info[LM].mem & ~d_mem_resp;
    fetch_stall = v_if & ~i_mem_resp;
    if (FWD_EN) raw_stall = (m_a[EX] | m_b[EX]) & info[EX].load;
    else        raw_stall = |(m_a | m_b);
    any_stall   = ~flush & (mem_stall | raw_stall | fetch_stall);
    d_mem_req   = info[LM].valid & info[LM].mem & ~flush;

    // Producer in EX moves to MEM next cycle; any MEM-stage producer is one step from WB.
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (FWD_EN) begin
      if (m_a[EX]) sel_a = FWD_MEM;
      else if (|m_a[EX+1:LM]) sel_a = FWD_WB;
      if (m_b[EX]) sel_b = FWD_MEM;
      else if (|m_b[EX+1:LM]) sel_b = FWD_WB;
    end

    stage_load = '0;
    if (!reset) begin
      stage_load[0] = flush | ~(mem_stall | raw_stall | fetch_stall);
      stage_load[1] = flush | ~(mem_stall | raw_stall);
      for (int s = EX; s <= LM; s++) stage_load[s] = flush | ~mem_stall;
      stage_load[WB] = 1'b1;
    end

    stage_valid    = '0;
    stage_valid[0] = v_if;
    stage_valid[1] = v_id;
    for (int s = EX; s <= WB; s++) stage_valid[s] = info[s].valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_if      <= 1'b0;
      v_id      <= 1'b0;
      for (int s = EX; s <= WB; s++) info[s] <= STAGE_BUBBLE;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
      stall_cnt <= '0;
    end else begin
      v_if <= ~flush;
      if (flush) begin
        v_id <= 1'b0;
        for (int s = EX; s <= WB; s++) info[s] <= STAGE_BUBBLE;
        fwd_a_sel <= FWD_RF;
        fwd_b_sel <= FWD_RF;
      end else if (mem_stall) begin
        info[WB] <= STAGE_BUBBLE;
      end else begin
        if (raw_stall) begin
          info[EX]  <= STAGE_BUBBLE;
          fwd_a_sel <= FWD_RF;
          fwd_b_sel <= FWD_RF;
        end else begin
          v_id      <= v_if & i_mem_resp;
          info[EX]  <= '{valid: id_valid, dest: id_dest, wr: id_wr,
                         load: id_load, mem: id_mem, branch: id_branch};
          fwd_a_sel <= sel_a;
          fwd_b_sel <= sel_b;
        end
        for (int s = EX + 1; s <= WB; s++) info[s] <= info[s-1];
      end
      if (any_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lc3b_pipe_ctrl.sv
// tb/tb_lc3b_pipe_ctrl.sv - directed bench for lc3b_pipe_ctrl
module tb_lc3b_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_mem_resp, d_mem_resp, wb_taken;
  logic       id_valid, id_use1, id_use2, id_wr, id_load, id_mem, id_branch;
  logic [2:0] id_src1, id_src2, id_dest;

  logic [4:0]  d_load, d_valid, z_load, z_valid, s_load, s_valid;
  logic        d_req, d_flush, z_req, z_flush, s_req, s_flush;
  logic [1:0]  d_fa, d_fb, z_fa, z_fb, s_fa, s_fb;
  logic [15:0] d_cnt, z_cnt;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc3b_pipe_ctrl dut (
    .clk(clk), .reset(reset), .i_mem_resp(i_mem_resp), .d_mem_resp(d_mem_resp),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1),
    .id_use2(id_use2), .id_dest(id_dest), .id_wr(id_wr), .id_load(id_load),
    .id_mem(id_mem), .id_branch(id_branch), .wb_taken(wb_taken),
    .stage_load(d_load), .stage_valid(d_valid), .d_mem_req(d_req), .flush(d_flush),
    .fwd_a_sel(d_fa), .fwd_b_sel(d_fb), .stall_cnt(d_cnt)
  );

  lc3b_pipe_ctrl #(.FWD_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .i_mem_resp(i_mem_resp), .d_mem_resp(d_mem_resp),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1),
    .id_use2(id_use2), .id_dest(id_dest), .id_wr(id_wr), .id_load(id_load),
    .id_mem(id_mem), .id_branch(id_branch), .wb_taken(wb_taken),
    .stage_load(z_load), .stage_valid(z_valid), .d_mem_req(z_req), .flush(z_flush),
    .fwd_a_sel(z_fa), .fwd_b_sel(z_fb), .stall_cnt(z_cnt)
  );

  lc3b_pipe_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .i_mem_resp(i_mem_resp), .d_mem_resp(d_mem_resp),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1),
    .id_use2(id_use2), .id_dest(id_dest), .id_wr(id_wr), .id_load(id_load),
    .id_mem(id_mem), .id_branch(id_branch), .wb_taken(wb_taken),
    .stage_load(s_load), .stage_valid(s_valid), .d_mem_req(s_req), .flush(s_flush),
    .fwd_a_sel(s_fa), .fwd_b_sel(s_fb), .stall_cnt(s_cnt)
  );

  typedef struct {
    logic       iv;
    logic [2:0] s1;
    logic       u1;
    logic [2:0] s2;
    logic       u2;
    logic [2:0] d;
    logic       wr, ld, mm, br;
    logic [4:0] e_load, e_valid;
    logic [1:0] e_fa, e_fb;
    logic       e_req;
    int         e_cnt;
  } row_t;

  row_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic iv, input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2, input logic [2:0] d,
                        input logic wr, input logic ld, input logic mm, input logic br);
    id_valid = iv; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
    id_dest = d; id_wr = wr; id_load = ld; id_mem = mm; id_branch = br;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_mem_resp = 1; d_mem_resp = 1; wb_taken = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      idle();
      @(negedge clk);
    end
  endtask

  task automatic load_ldr();
    set_id(1, 6, 1, 0, 0, 3, 1, 1, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ADD R1; ADD R2,R1,R1; LDR R3; ADD R4,R3; ADD R0; use R0,R0
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00001, 0, 0, 0, 0};
    tbl[2]  = '{1, 5, 1, 6, 1, 1, 1, 0, 0, 0, 5'b11111, 5'b00011, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 5'b11111, 5'b00111, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b01111, 1, 1, 0, 0};
    tbl[5]  = '{1, 6, 1, 0, 0, 3, 1, 1, 1, 0, 5'b11111, 5'b11011, 0, 0, 0, 0};
    tbl[6]  = '{1, 3, 1, 3, 0, 4, 1, 0, 0, 0, 5'b11100, 5'b10111, 0, 0, 0, 0};
    tbl[7]  = '{1, 3, 1, 3, 0, 4, 1, 0, 0, 0, 5'b11111, 5'b01011, 0, 0, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b10111, 2, 0, 0, 1};
    tbl[9]  = '{1, 7, 1, 7, 0, 0, 1, 0, 0, 0, 5'b11111, 5'b01011, 0, 0, 0, 1};
    tbl[10] = '{1, 0, 1, 0, 1, 5, 0, 0, 0, 0, 5'b11111, 5'b10111, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b01111, 1, 1, 0, 1};

    reset = 1;
    idle();
    @(negedge clk);
    chk("reset load",  d_load, 0);
    chk("reset valid", d_valid, 0);
    chk("reset fwd",   {d_fa, d_fb}, 0);
    chk("reset req",   {d_req, d_flush}, 0);
    chk("reset cnt",   d_cnt, 0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 12; i++) begin
      set_id(tbl[i].iv, tbl[i].s1, tbl[i].u1, tbl[i].s2, tbl[i].u2, tbl[i].d,
             tbl[i].wr, tbl[i].ld, tbl[i].mm, tbl[i].br);
      #1;
      chk($sformatf("row%0d load", i),  d_load,  tbl[i].e_load);
      chk($sformatf("row%0d valid", i), d_valid, tbl[i].e_valid);
      chk($sformatf("row%0d fwd_a", i), d_fa,    tbl[i].e_fa);
      chk($sformatf("row%0d fwd_b", i), d_fb,    tbl[i].e_fb);
      chk($sformatf("row%0d req", i),   d_req,   tbl[i].e_req);
      chk($sformatf("row%0d flush", i), d_flush, 0);
      chk($sformatf("row%0d cnt", i),   d_cnt,   tbl[i].e_cnt);
      @(negedge clk);
    end

    // No forwarding: ADD R1 then ADD R2,R1 waits until R1 leaves WB.
    do_reset();
    idle_cycles(2);
    set_id(1, 5, 1, 6, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      set_id(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
      #1;
      chk($sformatf("nofwd load c%0d", k), z_load, (k < 3) ? 5'b11100 : 5'b11111);
      if (k == 0) chk("fwd on no stall", d_load, 5'b11111);
      @(negedge clk);
    end
    idle();
    #1;
    chk("nofwd fwd_a", z_fa, 0);
    chk("nofwd fwd_b", z_fb, 0);
    chk("nofwd cnt",   z_cnt, 3);
    chk("nofwd ex valid", z_valid[2], 1);
    @(negedge clk);

    // Load held in MEM for four cycles.
    do_reset();
    idle_cycles(2);
    load_ldr();
    @(negedge clk);
    idle_cycles(1);
    for (int k = 0; k < 4; k++) begin
      idle();
      d_mem_resp = 0;
      #1;
      chk($sformatf("mstall load c%0d", k),  d_load,  5'b10000);
      chk($sformatf("mstall valid c%0d", k), d_valid, 5'b01011);
      chk($sformatf("mstall req c%0d", k),   d_req,   1);
      @(negedge clk);
    end
    idle();
    #1;
    chk("mstall resume load", d_load, 5'b11111);
    @(negedge clk);
    #1;
    chk("mstall wb valid", d_valid, 5'b10011);
    chk("mstall cnt",      d_cnt, 4);
    chk("sat cnt",         s_cnt, 3);
    @(negedge clk);

    // Taken branch in WB while the following load stalls in MEM.
    do_reset();
    idle_cycles(2);
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    load_ldr();
    @(negedge clk);
    idle_cycles(1);
    d_mem_resp = 0;
    #1;
    chk("pre flush req",   d_req, 1);
    chk("pre flush flush", d_flush, 0);
    wb_taken = 1;
    #1;
    chk("flush flag", d_flush, 1);
    chk("flush req",  d_req, 0);
    chk("flush load", d_load, 5'b11111);
    @(negedge clk);
    idle();
    #1;
    chk("post flush valid", d_valid, 0);
    chk("post flush flag",  d_flush, 0);
    chk("post flush cnt",   d_cnt, 0);
    @(negedge clk);

    // Reset asserted in the middle of a memory stall.
    do_reset();
    idle_cycles(2);
    load_ldr();
    @(negedge clk);
    idle_cycles(1);
    d_mem_resp = 0;
    @(negedge clk);
    #1;
    chk("pre reset cnt",  d_cnt, 1);
    chk("pre reset load", d_load, 5'b10000);
    #2;
    reset = 1;
    #1;
    chk("async load",  d_load, 0);
    chk("async valid", d_valid, 0);
    chk("async req",   {d_req, d_flush}, 0);
    chk("async fwd",   {d_fa, d_fb}, 0);
    chk("async cnt",   d_cnt, 0);
    @(negedge clk);
    reset = 0;
    idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
